// File: rtl/issue_tracker_if.sv
// Decode/writeback side of the issue tracker: issue request, retire and flush
// inputs plus the stall/tag/occupancy outputs the pipeline consumes.
interface issue_tracker_if #(
   parameter int DEPTH = 4
);
   localparam int TAG_W = $clog2(DEPTH);

   logic             issue_valid_D;
   logic [4:0]       rs1_addr_D;
   logic [4:0]       rs2_addr_D;
   logic             uses_rs1_D;
   logic             uses_rs2_D;
   logic [4:0]       rd_addr_D;
   logic             writes_rd_D;
   logic             stall_D;
   logic             issue_accept_D;
   logic [TAG_W-1:0] issue_tag_D;
   logic             retire_valid_W;
   logic [TAG_W-1:0] retire_tag_W;
   logic             flush_valid;
   logic [TAG_W-1:0] flush_tag;
   logic [TAG_W:0]   count;
   logic             empty;
   logic             full;
   logic             err;

   // Handshake: an instruction is taken at the clock edge exactly when
   // issue_valid_D is high and stall_D is low (reported as issue_accept_D);
   // retire and flush are single-cycle strobes with no back-pressure.
   modport master (
      output issue_valid_D, rs1_addr_D, rs2_addr_D, uses_rs1_D, uses_rs2_D,
      output rd_addr_D, writes_rd_D, retire_valid_W, retire_tag_W,
      output flush_valid, flush_tag,
      input  stall_D, issue_accept_D, issue_tag_D, count, empty, full, err
   );

   modport slave (
      input  issue_valid_D, rs1_addr_D, rs2_addr_D, uses_rs1_D, uses_rs2_D,
      input  rd_addr_D, writes_rd_D, retire_valid_W, retire_tag_W,
      input  flush_valid, flush_tag,
      output stall_D, issue_accept_D, issue_tag_D, count, empty, full, err
   );
endinterface

// File: rtl/issue_tracker.sv
// In-order tagged FIFO of in-flight instructions: allocates issue tags, frees
// them at writeback, squashes younger entries on flush and raises decode stalls.
module issue_tracker #(
   parameter int DEPTH = 4
) (
   input logic             clk,
   input logic             rst,
   issue_tracker_if.slave  bus
);
   localparam int TAG_W = $clog2(DEPTH);
   localparam int CW    = TAG_W + 1;

   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] r_writes;
   logic [4:0]       r_rd [DEPTH];
   logic [TAG_W-1:0] r_head;
   logic [TAG_W-1:0] r_tail;
   logic [CW-1:0]    r_count;
   logic             r_err;

   logic [DEPTH-1:0] w_valid_n;
   logic [DEPTH-1:0] w_writes_n;
   logic [4:0]       w_rd_n [DEPTH];
   logic [TAG_W-1:0] w_head_n;
   logic [TAG_W-1:0] w_tail_n;
   logic [CW-1:0]    w_count_n;
   logic             w_err_n;
   logic             w_hazard;
   logic             w_full;
   logic             w_accept;
   logic             w_retire_legal;
   logic             w_flush_legal;
   logic [TAG_W-1:0] w_flush_dist;
   logic [TAG_W-1:0] w_age;
   logic [CW-1:0]    w_retire_dec;

   // x0 is never recorded as busy; a retiring entry still blocks this cycle.
   always_comb begin
      w_hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_valid[i] && r_writes[i] && (r_rd[i] != 5'd0)) begin
            if (bus.uses_rs1_D && (r_rd[i] == bus.rs1_addr_D)) w_hazard = 1'b1;
            if (bus.uses_rs2_D && (r_rd[i] == bus.rs2_addr_D)) w_hazard = 1'b1;
            if (bus.writes_rd_D && (r_rd[i] == bus.rd_addr_D)) w_hazard = 1'b1;
         end
      end
   end

   assign w_full   = (r_count == CW'(DEPTH));
   assign w_accept = bus.issue_valid_D & ~bus.stall_D & ~rst;

   assign bus.stall_D        = rst | (bus.issue_valid_D & (w_hazard | w_full | bus.flush_valid));
   assign bus.issue_accept_D = w_accept;
   assign bus.issue_tag_D    = r_tail;
   assign bus.count          = r_count;
   assign bus.empty          = (r_count == '0);
   assign bus.full           = w_full;
   assign bus.err            = r_err;

   assign w_retire_legal = bus.retire_valid_W && (r_count != '0) && (bus.retire_tag_W == r_head);
   assign w_flush_dist   = bus.flush_tag - r_head;
   assign w_flush_legal  = bus.flush_valid && (CW'(w_flush_dist) < r_count);
   assign w_retire_dec   = CW'(w_retire_legal);
   assign w_err_n        = (bus.retire_valid_W & ~w_retire_legal) |
                           (bus.flush_valid & ~w_flush_legal);

   always_comb begin
      w_valid_n  = r_valid;
      w_writes_n = r_writes;
      w_rd_n     = r_rd;
      w_head_n   = r_head;
      w_tail_n   = r_tail;
      w_count_n  = r_count - w_retire_dec;
      w_age      = '0;
      if (w_retire_legal) begin
         w_valid_n[r_head] = 1'b0;
         w_head_n          = r_head + TAG_W'(1);
      end
      if (w_flush_legal) begin
         // Age is measured from head, so "younger than flush_tag" is age > dist.
         for (int i = 0; i < DEPTH; i++) begin
            w_age = TAG_W'(i) - r_head;
            if (w_age > w_flush_dist) w_valid_n[i] = 1'b0;
         end
         w_tail_n  = bus.flush_tag + TAG_W'(1);
         w_count_n = CW'(w_flush_dist) + CW'(1) - w_retire_dec;
      end else if (w_accept) begin
         w_valid_n[r_tail]  = 1'b1;
         w_writes_n[r_tail] = bus.writes_rd_D;
         w_rd_n[r_tail]     = bus.rd_addr_D;
         w_tail_n           = r_tail + TAG_W'(1);
         w_count_n          = r_count + CW'(1) - w_retire_dec;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid  <= '0;
         r_writes <= '0;
         for (int i = 0; i < DEPTH; i++) r_rd[i] <= 5'd0;
         r_head   <= '0;
         r_tail   <= '0;
         r_count  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_valid  <= w_valid_n;
         r_writes <= w_writes_n;
         r_rd     <= w_rd_n;
         r_head   <= w_head_n;
         r_tail   <= w_tail_n;
         r_count  <= w_count_n;
         r_err    <= w_err_n;
      end
   end
endmodule

// File: tb/tb_issue_tracker.sv
// Directed bench for issue_tracker: each step pushes hand-computed expected
// outputs; a monitor on the falling edge pops and compares them.
module tb_issue_tracker;
   localparam int DEPTH = 4;
   localparam int W     = 10;

   logic clk;
   logic rst;

   issue_tracker_if #(.DEPTH(DEPTH)) bus ();

   issue_tracker #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           checks = 0;
   int           errors = 0;

   // Clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: expected word is {stall, accept, tag[1:0], count[2:0], empty, full, err}
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         logic [W-1:0] exp_v;
         logic [W-1:0] act_v;
         string        nm;
         exp_v = exp_q.pop_front();
         nm    = name_q.pop_front();
         act_v = {bus.stall_D, bus.issue_accept_D, bus.issue_tag_D, bus.count,
                  bus.empty, bus.full, bus.err};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got stall/acc/tag/cnt/emp/full/err=%b_%b_%0d_%0d_%b_%b_%b expected %b_%b_%0d_%0d_%b_%b_%b",
                     nm, act_v[9], act_v[8], act_v[7:6], act_v[5:3], act_v[2], act_v[1], act_v[0],
                     exp_v[9], exp_v[8], exp_v[7:6], exp_v[5:3], exp_v[2], exp_v[1], exp_v[0]);
         end
      end
   end

   // Driver tasks
   task automatic clr();
      bus.issue_valid_D  = 1'b0;
      bus.rs1_addr_D     = 5'd0;
      bus.rs2_addr_D     = 5'd0;
      bus.uses_rs1_D     = 1'b0;
      bus.uses_rs2_D     = 1'b0;
      bus.rd_addr_D      = 5'd0;
      bus.writes_rd_D    = 1'b0;
      bus.retire_valid_W = 1'b0;
      bus.retire_tag_W   = 2'd0;
      bus.flush_valid    = 1'b0;
      bus.flush_tag      = 2'd0;
   endtask

   task automatic iss(input logic [4:0] rd, input logic wr, input logic [4:0] rs1,
                      input logic u1, input logic [4:0] rs2, input logic u2);
      bus.issue_valid_D = 1'b1;
      bus.rd_addr_D     = rd;
      bus.writes_rd_D   = wr;
      bus.rs1_addr_D    = rs1;
      bus.uses_rs1_D    = u1;
      bus.rs2_addr_D    = rs2;
      bus.uses_rs2_D    = u2;
   endtask

   task automatic ret(input logic [1:0] tag);
      bus.retire_valid_W = 1'b1;
      bus.retire_tag_W   = tag;
   endtask

   task automatic fl(input logic [1:0] tag);
      bus.flush_valid = 1'b1;
      bus.flush_tag   = tag;
   endtask

   // Push the expectation for the current inputs, then advance one cycle.
   task automatic step(input string nm, input logic st, input logic ac,
                       input logic [1:0] tg, input logic [2:0] cn, input logic er);
      logic ex_empty;
      logic ex_full;
      ex_empty = (cn == 3'd0);
      ex_full  = (cn == 3'd4);
      exp_q.push_back({st, ac, tg, cn, ex_empty, ex_full, er});
      name_q.push_back(nm);
      @(posedge clk);
      #1;
      clr();
   endtask

   initial begin
      rst = 1'b1;
      clr();
      @(posedge clk);
      #1;

      // Reset override while decode presents an instruction
      iss(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      step("rst_hold", 1, 0, 0, 0, 0);
      rst = 1'b0;

      // RAW on x5 until the cycle after the producer retires
      iss(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);  step("add_x5", 0, 1, 0, 0, 0);
      iss(5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);  step("raw_stall", 1, 0, 1, 1, 0);
      iss(5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0); ret(2'd0);
      step("raw_retire_cyc", 1, 0, 1, 1, 0);
      iss(5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);  step("raw_accept", 0, 1, 1, 0, 0);
      ret(2'd1);                                 step("retire_t1", 0, 0, 2, 1, 0);

      // x0 never busy; WAW on x7
      iss(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);  step("wr_x0", 0, 1, 2, 0, 0);
      iss(5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);  step("rd_x0", 0, 1, 3, 1, 0);
      iss(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);  step("wr_x7", 0, 1, 0, 2, 0);
      iss(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);  step("waw_stall", 1, 0, 1, 3, 0);
      iss(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); ret(2'd2);
      step("waw_ret2", 1, 0, 1, 3, 0);
      iss(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); ret(2'd3);
      step("waw_ret3", 1, 0, 1, 2, 0);
      iss(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); ret(2'd0);
      step("waw_ret0", 1, 0, 1, 1, 0);
      iss(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);  step("waw_accept", 0, 1, 1, 0, 0);
      ret(2'd1);                                 step("waw_drain", 0, 0, 2, 1, 0);

      // Full, and a same-cycle retire does not unblock issue
      rst = 1'b1;                                step("rst2", 1, 0, 2, 0, 0);
      rst = 1'b0;
      iss(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);  step("fill0", 0, 1, 0, 0, 0);
      iss(5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);  step("fill1", 0, 1, 1, 1, 0);
      iss(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);  step("fill2", 0, 1, 2, 2, 0);
      iss(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);  step("fill3", 0, 1, 3, 3, 0);
      iss(5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); ret(2'd0);
      step("full_stall", 1, 0, 0, 4, 0);
      iss(5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step("wrap_accept", 0, 1, 0, 3, 0);
      step("full_again", 0, 0, 1, 4, 0);

      // Flush with simultaneous retire
      rst = 1'b1;                                step("rst3", 1, 0, 1, 4, 0);
      rst = 1'b0;
      iss(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);  step("g_fill0", 0, 1, 0, 0, 0);
      iss(5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);  step("g_fill1", 0, 1, 1, 1, 0);
      iss(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);  step("g_fill2", 0, 1, 2, 2, 0);
      iss(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);  step("g_fill3", 0, 1, 3, 3, 0);
      iss(5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0); fl(2'd1); ret(2'd0);
      step("flush_ret", 1, 0, 0, 4, 0);
      iss(5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);  step("post_flush_rd3", 0, 1, 2, 1, 0);
      iss(5'd0, 1'b0, 5'd2, 1'b1, 5'd0, 1'b0);  step("survivor_x2_busy", 1, 0, 3, 2, 0);
      fl(2'd2);                                  step("flush_youngest", 0, 0, 3, 2, 0);
      ret(2'd1);                                 step("g_ret1", 0, 0, 3, 2, 0);
      ret(2'd2);                                 step("g_ret2", 0, 0, 3, 1, 0);

      // Illegal retire on empty tracker: one-cycle err pulse
      ret(2'd3);                                 step("ret_empty", 0, 0, 3, 0, 0);
      step("err_pulse_a", 0, 0, 3, 0, 1);
      step("err_clear_a", 0, 0, 3, 0, 0);

      // Illegal flush, then wrong-tag retire
      rst = 1'b1;                                step("rst4", 1, 0, 3, 0, 0);
      rst = 1'b0;
      iss(5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);  step("h_wr_x6", 0, 1, 0, 0, 0);
      fl(2'd2);                                  step("bad_flush", 0, 0, 1, 1, 0);
      ret(2'd1);                                 step("bad_retire", 0, 0, 1, 1, 1);
      step("err_pulse_b", 0, 0, 1, 1, 1);
      step("err_clear_b", 0, 0, 1, 1, 0);
      iss(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);  step("x6_still_busy", 1, 0, 1, 1, 0);

      // Reset with entries pending discards them
      iss(5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);  step("i_wr_x8", 0, 1, 1, 1, 0);
      iss(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);  step("i_wr_x9", 0, 1, 2, 2, 0);
      rst = 1'b1;
      iss(5'd11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step("rst_pending", 1, 0, 3, 3, 0);
      iss(5'd11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step("rst_pending2", 1, 0, 0, 0, 0);
      rst = 1'b0;
      iss(5'd9, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1);  step("after_rst_free", 0, 1, 0, 0, 0);

      // Issue and retire in one cycle keep count
      iss(5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); ret(2'd0);
      step("issue_and_retire", 0, 1, 1, 1, 0);
      step("count_kept", 0, 0, 2, 1, 0);

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
